// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the iir_inverse_n all-pole filter.
// Defining IIR_SATURATE_EN makes iir_reduce clamp the result; otherwise it wraps modulo 2^N.
package iir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, OUT} iir_state_t;

   localparam int IIR_N       = 32;
   localparam int IIR_DELAYS  = 3;
   localparam int IIR_ACC_W   = 2 * IIR_N + $clog2(IIR_DELAYS + 1);

   // iir_reduce works on a fixed wide accumulator so any N up to RED_W can share it
   localparam int RED_W       = 64;
   localparam int RED_ACC_W   = 2 * RED_W + 8;

   function automatic logic [RED_W-1:0] iir_reduce(input logic signed [RED_ACC_W-1:0] acc,
                                                   input int n);
`ifdef IIR_SATURATE_EN
      logic signed [RED_ACC_W-1:0] one, hi, lo;
      one = RED_ACC_W'(1);
      hi  = (one <<< (n - 1)) - one;
      lo  = -(one <<< (n - 1));
      if (acc > hi)
         return hi[RED_W-1:0];
      else if (acc < lo)
         return lo[RED_W-1:0];
      else
         return acc[RED_W-1:0];
`else
      return acc[RED_W-1:0];
`endif
   endfunction

endpackage

// File: rtl/iir_mac.sv
// Single signed multiply-subtract-accumulate datapath: acc <= acc - coef*hist.
// acc_next exposes the step result combinationally so the last tap can be retired directly.
module iir_mac
   import iir_pkg::*;
#(
   parameter int N     = IIR_N,
   parameter int ACC_W = IIR_ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic                    clear,
   input  logic                    load,
   input  logic                    step,
   input  logic signed [N-1:0]     load_val,
   input  logic signed [N-1:0]     coef,
   input  logic signed [N-1:0]     hist,
   output logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] acc_next
);

   logic signed [2*N-1:0] product;

   assign product  = (2*N)'(coef) * (2*N)'(hist);
   assign acc_next = acc - ACC_W'(product);

   // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         acc <= '0;
      else if (ena) begin
         if (clear)
            acc <= '0;
         else if (load)
            acc <= ACC_W'(load_val);
         else if (step)
            acc <= acc_next;
      end
   end

endmodule

// File: rtl/iir_inverse_n.sv
// Time-multiplexed all-pole IIR y[n] = x[n] - sum a[k]*y[n-k], one multiplier over DELAYS cycles.
// Result reduction saturates when IIR_SATURATE_EN is defined, wraps modulo 2^N otherwise.
module iir_inverse_n
   import iir_pkg::*;
#(
   parameter int DELAYS = IIR_DELAYS,
   parameter int N      = IIR_N
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [DELAYS*N-1:0]   a,
   input  logic [N-1:0]          x_in,
   input  logic                  x_valid,
   output logic                  x_ready,
   output logic [N-1:0]          y_out,
   output logic                  y_valid,
   input  logic                  y_ready
);

   localparam int KW = $clog2(DELAYS + 1);
   localparam int AW = 2 * N + $clog2(DELAYS + 1);

   iir_state_t              state;
   logic [KW-1:0]           k;
   logic signed [N-1:0]     y_hist [1:DELAYS];
   logic signed [N-1:0]     coef   [1:DELAYS];
   logic signed [AW-1:0]    acc, acc_next;
   logic [N-1:0]            result;
   logic                    accept, retire;

   always_comb begin
      for (int i = 1; i <= DELAYS; i++)
         coef[i] = a[(i-1)*N +: N];
   end

   assign accept = (state == IDLE) && x_ready && x_valid;
   assign retire = (state == OUT) && y_valid && y_ready;
   assign result = N'(iir_reduce(RED_ACC_W'(acc_next), N));

   iir_mac #(.N(N), .ACC_W(AW)) u_mac (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .clear    (retire),
      .load     (accept),
      .step     (state == MAC),
      .load_val (x_in),
      .coef     (coef[k]),
      .hist     (y_hist[k]),
      .acc      (acc),
      .acc_next (acc_next)
   );

   // NOTE: the history is a short register chain, so it is reset explicitly; a mid-sample reset must leave no stale feedback.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         k       <= '0;
         y_out   <= '0;
         y_valid <= 1'b0;
         x_ready <= 1'b0;
         for (int i = 1; i <= DELAYS; i++)
            y_hist[i] <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  x_ready <= 1'b0;
                  k       <= KW'(1);
                  state   <= MAC;
               end else
                  x_ready <= 1'b1;
            end
            MAC: begin
               // The final tap's result goes straight to y_out, saving a drain cycle
               if (k == KW'(DELAYS)) begin
                  k       <= '0;
                  y_out   <= result;
                  y_valid <= 1'b1;
                  state   <= OUT;
               end else
                  k <= k + KW'(1);
            end
            OUT: begin
               if (retire) begin
                  for (int i = DELAYS; i > 1; i--)
                     y_hist[i] <= y_hist[i-1];
                  y_hist[1] <= y_out;
                  y_valid   <= 1'b0;
                  x_ready   <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic unused_acc;
   assign unused_acc = ^acc;

endmodule

// File: tb/tb_iir_inverse_n.sv
// Directed self-checking bench for iir_inverse_n (DELAYS = 3, N = 32).
// Expected overflow value follows IIR_SATURATE_EN when it is defined.
module tb_iir_inverse_n;

   localparam int DELAYS = 3;
   localparam int N      = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 ena;
   logic [DELAYS*N-1:0]  a;
   logic [N-1:0]         x_in;
   logic                 x_valid;
   logic                 x_ready;
   logic [N-1:0]         y_out;
   logic                 y_valid;
   logic                 y_ready;

   int n_checks = 0;
   int n_fail   = 0;

   iir_inverse_n #(.DELAYS(DELAYS), .N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .a       (a),
      .x_in    (x_in),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .y_out   (y_out),
      .y_valid (y_valid),
      .y_ready (y_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic set_taps(input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
      a = {a3, a2, a1};
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // One sample through the block; hold = cycles y_ready stays low, stall = cycles ena drops in MAC
   task automatic send(input logic [31:0] x, input int hold, input int stall,
                       output logic [31:0] y, output int lat);
      int guard;
      guard = 0;
      while (!x_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("x_ready_before_send", {31'b0, x_ready}, 32'd1);
      x_in    = x;
      x_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      x_valid = 1'b0;
      x_in    = '0;
      lat     = 0;
      if (stall > 0) begin
         ena = 1'b0;
         repeat (stall) begin
            @(negedge clk);
            lat++;
         end
         ena = 1'b1;
      end
      while (!y_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      y = y_out;
      repeat (hold) begin
         @(negedge clk);
         check("hold_y_out", y_out, y);
         check("hold_y_valid", {31'b0, y_valid}, 32'd1);
         check("hold_x_ready", {31'b0, x_ready}, 32'd0);
      end
      y_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      y_ready = 1'b0;
      check("post_y_valid", {31'b0, y_valid}, 32'd0);
      check("post_x_ready", {31'b0, x_ready}, 32'd1);
   endtask

   logic [31:0] y;
   int          lat;
   int          guard;

   initial begin
      rst     = 1'b0;
      ena     = 1'b1;
      a       = '0;
      x_in    = 32'h55;
      x_valid = 1'b1;
      y_ready = 1'b0;

      // Reset with x_valid asserted
      repeat (3) @(negedge clk);
      check("rst_y_out", y_out, 32'd0);
      check("rst_y_valid", {31'b0, y_valid}, 32'd0);
      check("rst_x_ready", {31'b0, x_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rel_x_ready", {31'b0, x_ready}, 32'd1);
      check("rel_y_valid", {31'b0, y_valid}, 32'd0);
      x_valid = 1'b0;

      // Zero history: every tap active, zero input must give zero
      set_taps(32'd1, -32'sd2, 32'd4);
      send(32'd0, 0, 0, y, lat);
      check("hist_zero", y, 32'd0);

      // Impulse response with a1 = 2
      set_taps(32'd2, 32'd0, 32'd0);
      send(32'd1, 0, 0, y, lat);
      check("imp_y0", y, 32'd1);
      check("imp_latency", lat, 32'd3);
      send(32'd0, 0, 0, y, lat);
      check("imp_y1", y, -32'sd2);
      send(32'd0, 0, 0, y, lat);
      check("imp_y2", y, 32'd4);
      send(32'd0, 0, 0, y, lat);
      check("imp_y3", y, -32'sd8);

      // All three taps: a = {1, -2, 4}
      do_reset();
      set_taps(32'd1, -32'sd2, 32'd4);
      send(32'd1, 0, 0, y, lat);
      check("tap3_y0", y, 32'd1);
      send(32'd0, 0, 0, y, lat);
      check("tap3_y1", y, -32'sd1);
      send(32'd0, 0, 0, y, lat);
      check("tap3_y2", y, 32'd3);
      send(32'd0, 0, 0, y, lat);
      check("tap3_y3", y, -32'sd9);

      // Inverse of fir_n with b = {1, 3, 0, 0}
      do_reset();
      set_taps(32'd3, 32'd0, 32'd0);
      send(32'd5, 0, 0, y, lat);
      check("inv_y0", y, 32'd5);
      send(32'd15, 0, 0, y, lat);
      check("inv_y1", y, 32'd0);
      send(32'd0, 0, 0, y, lat);
      check("inv_y2", y, 32'd0);

      // Backpressure: y_ready low for 10 cycles
      set_taps(32'd0, 32'd0, 32'd0);
      send(32'h1234, 10, 0, y, lat);
      check("bp_y", y, 32'h1234);
      check("bp_latency", lat, 32'd3);
      @(negedge clk);
      check("bp_single_transfer", {31'b0, y_valid}, 32'd0);

      // Overflow with a1 = -1
      do_reset();
      set_taps(32'hFFFF_FFFF, 32'd0, 32'd0);
      send(32'h7FFF_FFFF, 0, 0, y, lat);
      check("ovf_y0", y, 32'h7FFF_FFFF);
      send(32'h7FFF_FFFF, 0, 0, y, lat);
`ifdef IIR_SATURATE_EN
      check("ovf_y1", y, 32'h7FFF_FFFF);
`else
      check("ovf_y1", y, 32'hFFFF_FFFE);
`endif

      // ena low for 5 cycles inside MAC
      do_reset();
      set_taps(32'd3, 32'd0, 32'd0);
      send(32'd2, 0, 0, y, lat);
      check("stall_pre", y, 32'd2);
      send(32'd10, 0, 5, y, lat);
      check("stall_y", y, 32'd4);
      check("stall_latency", lat, 32'd8);

      // Reset in the middle of MAC; history holds {4, 2, 0}
      guard = 0;
      while (!x_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      x_in    = 32'd9;
      x_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      x_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_y_valid", {31'b0, y_valid}, 32'd0);
      check("midrst_x_ready", {31'b0, x_ready}, 32'd0);
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("midrst_no_output", {31'b0, y_valid}, 32'd0);
      end
      send(32'd7, 0, 0, y, lat);
      check("midrst_next", y, 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iir_inverse_n.md
# iir_inverse_n

Time-multiplexed all-pole IIR filter that inverts a monic `fir_n` stage: y[n] = x[n] − Σ_{k=1..DELAYS} a[k]·y[n−k].
- It sits at the receive end of a channel shaped by `fir_n`. With a[k] equal to the FIR taps b[k] (b[0] = 1), it recovers the FIR's input sample stream.
- It uses one multiplier, iterated over DELAYS cycles per sample.
- Samples move on valid/ready handshakes at both input and output.

## Interface
- `DELAYS`, 3: feedback order; number of past outputs held.
- `N`, 32: sample and coefficient width, signed two's complement.

Ports:
- `clk`  in  1  sole clock; rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  global enable. Low freezes the FSM, counter, accumulator and history; outputs hold.
- `a`  in  DELAYS*N  feedback coefficients. a[k] occupies bits k*N−1 : (k−1)*N, for k = 1..DELAYS.
- `x_in`  in  N  input sample.
- `x_valid`  in  1  x_in valid.
- `x_ready`  out  1  block can accept a sample.
- `y_out`  out  N  output sample.
- `y_valid`  out  1  y_out valid.
- `y_ready`  in  1  downstream accepts y_out.

## Operation
- **Reset (rst = 0):**
  - State goes to IDLE.
  - History y_hist[1..DELAYS], accumulator, tap counter and y_out are cleared to 0.
  - y_valid = 0 and x_ready = 0 while rst is low.
- **IDLE:**
  - x_ready = 1.
  - On x_valid && ena: accumulator ← sign-extended x_in, tap counter k ← 1, next state MAC.
- **MAC:**
  - Each enabled cycle: acc ← acc − a[k]·y_hist[k], then k ← k+1.
  - After k = DELAYS the next state is OUT.
  - Occupies exactly DELAYS enabled cycles. x_ready = 0.
- **OUT:**
  - y_out = result and y_valid = 1; both hold stable until y_ready.
  - On y_valid && y_ready && ena: history shifts (y_hist[k+1] ← y_hist[k], y_hist[1] ← y_out), next state IDLE.
  - The oldest history entry is discarded.
- **Arithmetic:**
  - Products are full 2N bits.
  - The accumulator is 2N + clog2(DELAYS+1) bits signed.
  - The result is reduced to N bits per `## Configuration`. History stores the reduced N-bit value.
- **Coefficients:** `a` is read live, not latched. It must be stable from input acceptance until the output handshake. Changing it mid-sample gives an undefined result for that sample only.
- **Reset mid-operation:** an in-flight sample is discarded, with no partial output.
- **`ena` low:** in any state it stalls without losing state. Handshakes do not complete while `ena` is low.

## Timing
- x_in accepted at edge t → y_valid = 1 from cycle t+DELAYS+1, assuming ena stays high.
- Output handshake at edge u → x_ready = 1 at cycle u+1. No same-cycle bypass from OUT back to accept.
- Peak throughput is one sample per DELAYS+2 cycles.
- All outputs are registered. There is no combinational path from x_valid or y_ready to any output.

## Configuration
- `IIR_SATURATE_EN` defined: the result is clamped to [−2^(N−1), 2^(N−1)−1] before output and history.
- Not defined: the result is the low N bits of the accumulator (modulo 2^N wrap). This is bit-exact with the wrap behaviour of `fir_n` integer arithmetic.

## Structure
- Package `iir_pkg`:
  - `iir_state_t` enum (IDLE, MAC, OUT).
  - Function `iir_reduce(acc)` implementing saturate or wrap under the macro.
  - Localparam for accumulator width.
- Sub-module `iir_mac`: the single signed multiply-subtract-accumulate datapath, with load, step, enable and clear.
- The top level holds the FSM, tap counter, history shift register and handshake logic.

## Test plan
Use DELAYS = 3 and N = 32 throughout.
1. **Reset:** hold rst low with x_valid = 1 → y_out = 0, y_valid = 0, x_ready = 0. After release, x_ready = 1 next cycle and the history reads back as zeros.
2. **Impulse response:** a1 = 2, a2 = a3 = 0, inputs 1, 0, 0, 0 → outputs 1, −2, 4, −8.
3. **Inverse pairing:** `fir_n` with b = {1, 3, 0, 0} fed 5, 0, 0 gives 5, 15, 0. Feed those into this block with a1 = 3 → outputs 5, 0, 0.
4. **Backpressure and latency:**
   - Accept at edge t → y_valid rises at t+4.
   - Hold y_ready = 0 for 10 cycles → y_out stable and x_ready = 0 throughout.
   - Release y_ready → exactly one transfer, and x_ready = 1 the following cycle.
5. **Overflow:** a1 = −1, inputs 0x7FFFFFFF twice → second output is 0x7FFFFFFF with `IIR_SATURATE_EN`, 0xFFFFFFFE without.
6. **Stall and mid-operation reset:**
   - Drop ena for 5 cycles during MAC → the result is unchanged and latency grows by 5.
   - Assert rst during MAC → no y_valid, history is cleared, and the next input 7 gives output 7.
